fifo_burst_sched: RTL
=====================

// Module: fifo_burst_sched
// PURPOSE
//  Write-arbiter and burst read sequencer for the shared 16-bit sample FIFO (128 deep) in the DTW datapath.
//  Merges N_REQ producer streams into the FIFO write port with round-robin arbitration.
//  Tracks FIFO occupancy with internal counters; the FIFO's full/empty flags are not used for flow control.
//  Drains the FIFO to the DTW core in fixed BURST-word bursts, or a partial burst on flush.
// PARAMETERS
//  N_REQ  2   number of producer ports (2..4)
//  DW     16  sample width, signed
//  AW     7   FIFO address width; usable capacity 2**AW-1 = 127
//  BURST  8   words per burst (1..2**AW-1)
// PORTS
//  clock         in   1         single system clock, rising edge
//  sclr          in   1         synchronous active-high reset; also forwarded to fifo_sclr
//  req_valid     in   N_REQ     producer i has a sample
//  req_data      in   N_REQ*DW  producer i sample, slice [i*DW +: DW]
//  req_ready     out  N_REQ     one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
//  flush         in   1         pulse: emit the remaining committed words as a short burst
//  clr           in   1         pulse: soft clear of FIFO and counters
//  fifo_wrreq    out  1         registered write strobe to FIFO
//  fifo_data     out  DW        registered write data to FIFO
//  fifo_rdreq    out  1         read/advance strobe to FIFO (head shown combinationally on fifo_q)
//  fifo_q        in   DW        FIFO head word
//  fifo_sclr     out  1         FIFO synchronous clear
//  out_valid     out  1         burst word valid to DTW core
//  out_data      out  DW        = fifo_q
//  out_last      out  1         last word of the current burst
//  out_ready     in   1         DTW core accepts out_data
//  occupancy     out  AW        credit count (granted minus read)
// BEHAVIOUR
//  Reset (sclr=1): req_ready=0, fifo_wrreq=0, fifo_data=0, fifo_rdreq=0, out_valid=0, out_last=0,
//    occupancy=0, avail=0, rr pointer=0, state=IDLE; fifo_sclr=1 in the same cycle; clear the write pipeline.
//  Arbitration: round robin starting at the index after the last grant; at most one grant per cycle.
//    Grant only when occupancy < 2**AW-1 and state != CLEAR and no clr is pending.
//    req_ready is combinational from req_valid, the rr pointer and the credit check.
//  Write pipeline: a grant in cycle t drives fifo_wrreq/fifo_data in t+1.
//    The FIFO registers the strobe internally, so the word is readable from t+3.
//    A 3-stage commit shift register increments avail at t+3.
//  Counters:
//    occupancy +1 on grant and -1 on read; a simultaneous grant and read leaves it unchanged.
//    avail +1 on commit and -1 on read; commit and read may coincide.
//    avail <= occupancy always; neither wraps.
//  Read FSM:
//    IDLE  -> BURST   when avail >= BURST; cnt = BURST.
//    IDLE  -> BURST   when flush_pend && avail > 0; cnt = avail.
//    IDLE  -> clears flush_pend when flush_pend && avail == 0.
//    IDLE  -> CLEAR   when clr_pend; clr_pend has priority over starting a burst.
//    BURST: out_valid=1; fifo_rdreq = out_ready; cnt decrements per accepted word; out_last = (cnt==1).
//    BURST -> IDLE    on an accepted word with out_last=1.
//  Burst rules:
//    A flush burst latches its length at entry; later commits wait for the next burst.
//    flush_pend clears on entry to a flush burst.
//    out_ready low stalls the burst; fifo_rdreq=0 and the data holds.
//  clr and flush arriving during BURST are latched and honoured after the burst completes.
//  CLEAR: grants blocked; wait until the commit pipeline is empty.
//    Then assert fifo_sclr for 1 cycle, zero occupancy/avail/flush_pend/clr_pend, return to IDLE.
//  sclr mid-burst: the burst aborts immediately; out_last is not issued.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, BURST, CLEAR) and the CAP = 2**AW-1 constant.
//  One sub-module: rr_arbiter (N_REQ-wide, rotating priority, enable input).
//  Counters, commit pipeline and FSM sit in the top module.
// TESTING (bench instantiates the sample FIFO as the downstream)
//  1. One producer sends 8 words 1..8, out_ready=1.
//     -> one burst 1..8 in order; out_last on word 8; occupancy returns to 0.
//  2. Both producers valid every cycle, 0x1xx and 0x2xx.
//     -> grants alternate 0,1,0,1; the burst carries interleaved data; no sample lost or duplicated.
//  3. Fill 127 words with out_ready=0.
//     -> req_ready drops at occupancy=127, no write is lost, the FIFO never overflows.
//     -> release out_ready: 15 bursts drain, then 7 words remain.
//  4. 5 words then flush.
//     -> one burst of 5 with out_last on word 5.
//     -> flush with avail=0 produces no burst.
//  5. clr during a stalled burst.
//     -> the burst completes; fifo_sclr pulses once; occupancy=0; new writes then start cleanly.
//  6. sclr at word 3 of a burst.
//     -> out_valid=0 next cycle, all outputs at reset values, a fresh burst works afterwards.

Source files
------------

// File: rtl/fifo_burst_sched_pkg.sv
// Shared state encoding and FIFO capacity constants for the burst scheduler.
package fifo_burst_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_CLEAR = 2'd2
  } sched_state_t;

  localparam int FIFO_AW = 7;

  // One slot is sacrificed so a full FIFO is distinguishable from an empty one.
  function automatic int fifo_cap(input int aw);
    return (1 << aw) - 1;
  endfunction

  localparam int CAP = fifo_cap(FIFO_AW);

endpackage

// File: rtl/fifo_burst_sched_rr_arbiter.sv
// Purpose: rotating-priority one-hot grant across N requesters, gated by en.
// Latency: combinational grant; priority pointer advances on the clock after a grant.
// Backpressure: en low withholds every grant and freezes the pointer.
module fifo_burst_sched_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         sclr,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] idx;
  logic          hit;

  // ptr names the requester holding highest priority this cycle.
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    hit     = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (en && !hit && req[idx]) begin
        gnt[idx] = 1'b1;
        ptr_nxt  = PW'((int'(idx) + 1) % N);
        hit      = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/fifo_burst_sched.sv
// Purpose: round-robin write arbiter and fixed/flush burst read sequencer for the sample FIFO.
// Latency: grant -> fifo_wrreq next cycle; word eligible for a burst three cycles after grant.
// Backpressure: credit-based grants stop at CAP; out_ready low stalls a burst in place.
module fifo_burst_sched
  import fifo_burst_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DW    = 16,
  parameter int AW    = FIFO_AW,
  parameter int BURST = 8
) (
  input  logic                clock,
  input  logic                sclr,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                flush,
  input  logic                clr,
  output logic                fifo_wrreq,
  output logic [DW-1:0]       fifo_data,
  output logic                fifo_rdreq,
  input  logic [DW-1:0]       fifo_q,
  output logic                fifo_sclr,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [AW-1:0]       occupancy
);

  localparam logic [AW-1:0] CAP_V   = AW'(fifo_cap(AW));
  localparam logic [AW-1:0] BURST_V = AW'(BURST);

  sched_state_t   state;
  sched_state_t   state_nxt;
  logic [AW-1:0]  cnt;
  logic [AW-1:0]  cnt_nxt;
  logic [AW-1:0]  avail;
  logic [1:0]     commit_pipe;
  logic           flush_pend;
  logic           clr_pend;
  logic           flush_take;
  logic           grant_en;
  logic           grant;
  logic           rd;
  logic           clear_now;
  logic [N_REQ-1:0] gnt;
  logic [DW-1:0]  gnt_data;

  // A clr pulse blocks grants in its own cycle so nothing new lands behind the clear.
  assign grant_en = !sclr && (occupancy < CAP_V) && (state != ST_CLEAR) && !clr_pend && !clr;

  fifo_burst_sched_rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clock (clock),
    .sclr  (sclr),
    .en    (grant_en),
    .req   (req_valid),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign grant     = |gnt;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) gnt_data = req_data[i*DW +: DW];
    end
  end

  assign rd         = (state == ST_BURST) && out_ready;
  assign clear_now  = (state == ST_CLEAR) && (commit_pipe == 2'b00);
  assign fifo_rdreq = rd && !sclr;
  assign fifo_sclr  = sclr || clear_now;
  assign out_valid  = (state == ST_BURST) && !sclr;
  assign out_last   = out_valid && (cnt == AW'(1));
  assign out_data   = fifo_q;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    flush_take = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_pend) begin
          state_nxt = ST_CLEAR;
        end else if (avail >= BURST_V) begin
          state_nxt = ST_BURST;
          cnt_nxt   = BURST_V;
        end else if (flush_pend) begin
          flush_take = 1'b1;
          if (avail != '0) begin
            state_nxt = ST_BURST;
            cnt_nxt   = avail;
          end
        end
      end
      ST_BURST: begin
        if (out_ready) begin
          cnt_nxt = cnt - AW'(1);
          if (cnt == AW'(1)) state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (commit_pipe == 2'b00) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      occupancy   <= '0;
      avail       <= '0;
      commit_pipe <= '0;
      fifo_wrreq  <= 1'b0;
      fifo_data   <= '0;
      flush_pend  <= 1'b0;
      clr_pend    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      fifo_wrreq  <= grant;
      if (grant) fifo_data <= gnt_data;
      // Tracks the FIFO's own input register so avail only counts readable words.
      commit_pipe <= {commit_pipe[0], grant};
      if (clear_now) begin
        occupancy <= '0;
        avail     <= '0;
      end else begin
        occupancy <= occupancy + AW'(grant) - AW'(rd);
        avail     <= avail + AW'(commit_pipe[1]) - AW'(rd);
      end
      flush_pend <= flush || (flush_pend && !flush_take && !clear_now);
      clr_pend   <= clr || (clr_pend && !clear_now);
    end
  end

endmodule
